// File: rtl/dds_voice_osc.sv
// dds_voice_osc: single DDS voice oscillator.
//   Runs a phase accumulator once per sample_tick using the phase increment from
//   note_pitch2dds. It shapes the accumulator into a signed waveform (saw, square,
//   triangle, pulse) and gates the voice with click-free release at phase wrap.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   sample_tick  one-cycle strobe at the audio sample rate
//   gate         note-on level
//   sync         hard-sync request, sampled on sample_tick
//   wave_sel     0 saw, 1 square, 2 triangle, 3 pulse
//   pw           pulse width for the pulse waveform
//   adder        phase increment, sampled on sample_tick
//   sample       signed waveform sample (held between strobes)
//   sample_valid one-cycle strobe, two cycles after the tick
//   wrap         one-cycle strobe on accumulator carry-out, one cycle after the tick
//   active       voice is in RUN or DRAIN
module dds_voice_osc #(
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample_tick,
  input  logic                     gate,
  input  logic                     sync,
  input  logic [1:0]               wave_sel,
  input  logic [7:0]               pw,
  input  logic [PHASE_W-1:0]       adder,
  output logic signed [OUT_W-1:0]  sample,
  output logic                     sample_valid,
  output logic                     wrap,
  output logic                     active
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [PHASE_W-1:0]        phase_p1_q, phase_p1_d;
  logic                      vld_p1_q, vld_p1_d;
  logic                      wrap_p1_q, wrap_p1_d;
  logic                      active_p1_q, active_p1_d;
  logic signed [OUT_W-1:0]   sample_p2_q, sample_p2_d;
  logic                      vld_p2_q, vld_p2_d;
  logic [PHASE_W:0]          sum;

  // Waveform shaper working on the top OUT_W bits of the phase.
  function automatic logic signed [OUT_W-1:0] shape_sample(
    input logic [1:0]       sel,
    input logic [OUT_W-1:0] p,
    input logic [7:0]       width
  );
    logic [OUT_W-1:0] pos_max;
    logic [OUT_W-1:0] neg_min;
    logic [OUT_W-2:0] t;
    pos_max = {1'b0, {(OUT_W-1){1'b1}}};
    neg_min = {1'b1, {(OUT_W-1){1'b0}}};
    // Fold the upper half of the ramp back down to get a symmetric triangle.
    t = p[OUT_W-1] ? ~p[OUT_W-2:0] : p[OUT_W-2:0];
    case (sel)
      2'd0:    shape_sample = $signed(p ^ neg_min);
      2'd1:    shape_sample = $signed(p[OUT_W-1] ? neg_min : pos_max);
      2'd2:    shape_sample = $signed({t, 1'b0} ^ neg_min);
      default: shape_sample = $signed((p[OUT_W-1 -: 8] < width) ? pos_max : neg_min);
    endcase
  endfunction

  // Stage p1: state machine and phase accumulator, advanced only on ticks
  always_comb begin
    sum         = {1'b0, phase_p1_q} + {1'b0, adder};
    state_d     = state_q;
    phase_p1_d  = phase_p1_q;
    wrap_p1_d   = 1'b0;
    vld_p1_d    = sample_tick;
    if (sample_tick) begin
      case (state_q)
        ST_IDLE: begin
          phase_p1_d = '0;
          if (gate) state_d = ST_RUN;
        end
        ST_RUN: begin
          phase_p1_d = sum[PHASE_W-1:0];
          wrap_p1_d  = sum[PHASE_W];
          if (!gate) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          phase_p1_d = sum[PHASE_W-1:0];
          wrap_p1_d  = sum[PHASE_W];
          // Legato wins; otherwise a sync or the final carry ends the release at phase 0.
          if (gate) begin
            state_d = ST_RUN;
          end else if (sync || sum[PHASE_W]) begin
            state_d    = ST_IDLE;
            phase_p1_d = '0;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          phase_p1_d = '0;
        end
      endcase
      // Hard sync restarts the cycle and suppresses the wrap strobe; no effect in IDLE.
      if (sync && (state_q != ST_IDLE)) begin
        phase_p1_d = '0;
        wrap_p1_d  = 1'b0;
      end
    end
    active_p1_d = (state_d != ST_IDLE);
  end

  // Stage p2: shape the updated phase; IDLE voices emit silence
  always_comb begin
    vld_p2_d    = vld_p1_q;
    sample_p2_d = sample_p2_q;
    if (vld_p1_q) begin
      if (state_q == ST_IDLE) sample_p2_d = '0;
      else sample_p2_d = shape_sample(wave_sel, phase_p1_q[PHASE_W-1 -: OUT_W], pw);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_p1_q  <= '0;
      vld_p1_q    <= 1'b0;
      wrap_p1_q   <= 1'b0;
      active_p1_q <= 1'b0;
      sample_p2_q <= '0;
      vld_p2_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_p1_q  <= phase_p1_d;
      vld_p1_q    <= vld_p1_d;
      wrap_p1_q   <= wrap_p1_d;
      active_p1_q <= active_p1_d;
      sample_p2_q <= sample_p2_d;
      vld_p2_q    <= vld_p2_d;
    end
  end

  assign sample       = sample_p2_q;
  assign sample_valid = vld_p2_q;
  assign wrap         = wrap_p1_q;
  assign active       = active_p1_q;

endmodule

// File: tb/tb_dds_voice_osc.sv
// Testbench for dds_voice_osc: directed tick sequences push expected responses
// into a scoreboard; a negedge monitor pops one entry per sample_valid.
module tb_dds_voice_osc;

  logic               clk;
  logic               rst_n;
  logic               sample_tick;
  logic               gate;
  logic               sync;
  logic [1:0]         wave_sel;
  logic [7:0]         pw;
  logic [31:0]        adder;
  logic signed [15:0] sample;
  logic               sample_valid;
  logic               wrap;
  logic               active;

  dds_voice_osc #(.PHASE_W(32), .OUT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_tick  (sample_tick),
    .gate         (gate),
    .sync         (sync),
    .wave_sel     (wave_sel),
    .pw           (pw),
    .adder        (adder),
    .sample       (sample),
    .sample_valid (sample_valid),
    .wrap         (wrap),
    .active       (active)
  );

  typedef struct {
    logic [15:0] smp;
    logic        wrp;
    logic        act;
    int          tcyc;
    int          idx;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  string       cur_test = "reset";
  logic [15:0] last_smp = '0;
  logic        wrap_prev = 1'b0;
  logic        act_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act_v, exp_v);
    end
  endtask

  function automatic logic [15:0] saw_exp(input int k);
    logic [7:0] b;
    b = k[7:0];
    return {b, 8'h00} ^ 16'h8000;
  endfunction

  // Triangle as a piecewise-linear ramp: rises -32768..32766, then falls.
  function automatic logic [15:0] tri_exp(input int p);
    int v;
    if (p < 32768) v = 2 * p - 32768;
    else v = 32766 - 2 * (p - 32768);
    return v[15:0];
  endfunction

  // Monitor: one scoreboard entry per sample_valid, plus hold between strobes.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_smp = '0;
    end else if (sample_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got sample_valid=1 (sample %h) expected no pending sample", sample);
      end else begin
        e = sb.pop_front();
        chk($sformatf("%s[%0d] sample", cur_test, e.idx), {16'h0, sample}, {16'h0, e.smp});
        chk($sformatf("%s[%0d] wrap", cur_test, e.idx), {31'h0, wrap_prev}, {31'h0, e.wrp});
        chk($sformatf("%s[%0d] active", cur_test, e.idx), {31'h0, act_prev}, {31'h0, e.act});
        chk($sformatf("%s[%0d] latency", cur_test, e.idx), cyc - e.tcyc, 32'd2);
      end
      last_smp = sample;
    end else begin
      chk($sformatf("%s hold", cur_test), {16'h0, sample}, {16'h0, last_smp});
    end
    wrap_prev = wrap;
    act_prev  = active;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one tick for one cycle and record what it must produce.
  task automatic issue(input logic g, input logic s, input logic [31:0] a,
                       input logic [15:0] es, input logic ew, input logic ea, input int idx);
    exp_t e;
    gate        = g;
    sync        = s;
    adder       = a;
    sample_tick = 1'b1;
    e.smp  = es;
    e.wrp  = ew;
    e.act  = ea;
    e.tcyc = cyc;
    e.idx  = idx;
    sb.push_back(e);
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    sync        = 1'b0;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    sample_tick = 1'b0;
    gate        = 1'b0;
    sync        = 1'b0;
    sb.delete();
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] es;
    logic        ew;
    logic        ea;
    logic        g;
    logic        s;
    int          wait_cnt;

    rst_n = 1'b0; sample_tick = 1'b0; gate = 1'b0; sync = 1'b0;
    wave_sel = 2'd0; pw = 8'd0; adder = '0;
    @(posedge clk);
    #1;

    // Reset held for 3 cycles with tick/gate activity.
    for (int i = 0; i < 3; i++) begin
      sample_tick = (i != 1);
      gate        = (i != 2);
      @(posedge clk);
      #1;
      chk($sformatf("reset%0d sample", i), {16'h0, sample}, 32'h0);
      chk($sformatf("reset%0d valid", i), {31'h0, sample_valid}, 32'h0);
      chk($sformatf("reset%0d wrap", i), {31'h0, wrap}, 32'h0);
      chk($sformatf("reset%0d active", i), {31'h0, active}, 32'h0);
    end
    rst_n = 1'b1; sample_tick = 1'b0; gate = 1'b0;
    idle(2);

    // Saw start-up, tick every 4 cycles, wrap every 256 ticks.
    cur_test = "saw";
    wave_sel = 2'd0;
    for (int k = 0; k <= 520; k++) begin
      issue(1'b1, 1'b0, 32'h0100_0000, saw_exp(k), (k > 0) && (k % 256 == 0), 1'b1, k);
      idle(3);
    end

    // Reset while a tick is in flight: no stale sample_valid may follow.
    cur_test = "midreset";
    issue(1'b1, 1'b0, 32'h0100_0000, saw_exp(521), 1'b0, 1'b1, 521);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    chk("midreset sample", {16'h0, sample}, 32'h0);
    chk("midreset valid", {31'h0, sample_valid}, 32'h0);
    chk("midreset wrap", {31'h0, wrap}, 32'h0);
    chk("midreset active", {31'h0, active}, 32'h0);
    rst_n = 1'b1;
    gate  = 1'b0;
    idle(3);

    // Triangle, back-to-back ticks over one full period.
    cur_test = "tri";
    wave_sel = 2'd2;
    for (int k = 0; k <= 1024; k++)
      issue(1'b1, 1'b0, 32'h0040_0000, tri_exp((k * 64) & 32'hFFFF), (k == 1024), 1'b1, k);
    idle(3);

    // Gate release after tick 100: drains until the carry at tick 256.
    do_reset();
    cur_test = "release";
    wave_sel = 2'd0;
    for (int k = 0; k <= 260; k++) begin
      if (k <= 255) begin es = saw_exp(k); ew = 1'b0; ea = 1'b1; end
      else if (k == 256) begin es = 16'h0000; ew = 1'b1; ea = 1'b0; end
      else begin es = 16'h0000; ew = 1'b0; ea = 1'b0; end
      issue(k <= 100, 1'b0, 32'h0100_0000, es, ew, ea, k);
      idle(1);
    end

    // Legato re-trigger during DRAIN, sync in RUN, sync in DRAIN, sync in IDLE.
    cur_test = "legato";
    for (int k = 0; k <= 387; k++) begin
      g = (k < 10) || ((k >= 15) && (k <= 384));
      s = (k == 128) || (k == 386) || (k == 387);
      ew = 1'b0;
      ea = 1'b1;
      if (k <= 127) es = saw_exp(k);
      else if (k <= 384) begin es = saw_exp(k - 128); ew = (k == 384); end
      else if (k == 385) es = 16'h8100;
      else begin es = 16'h0000; ea = 1'b0; end
      issue(g, s, 32'h0100_0000, es, ew, ea, k);
      idle(1);
    end
    idle(2);

    // Pulse with pw=0x40, then pw=0, then square.
    cur_test = "pulse";
    wave_sel = 2'd3;
    pw       = 8'h40;
    for (int k = 0; k <= 300; k++) begin
      issue(1'b1, 1'b0, 32'h0100_0000, ((k % 256) < 64) ? 16'h7FFF : 16'h8000, (k == 256), 1'b1, k);
      idle(1);
    end
    idle(1);
    cur_test = "pw0";
    pw = 8'h00;
    for (int k = 301; k <= 320; k++) begin
      issue(1'b1, 1'b0, 32'h0100_0000, 16'h8000, 1'b0, 1'b1, k);
      idle(1);
    end
    idle(1);
    cur_test = "square";
    wave_sel = 2'd1;
    for (int k = 321; k <= 400; k++) begin
      issue(1'b1, 1'b0, 32'h0100_0000, ((k % 256) < 128) ? 16'h7FFF : 16'h8000, 1'b0, 1'b1, k);
      idle(1);
    end

    // Let the pipeline drain; every issued tick must have produced a sample.
    wait_cnt = 0;
    while ((sb.size() != 0) && (wait_cnt < 20)) begin
      idle(1);
      wait_cnt++;
    end
    chk("drain pending", sb.size(), 32'd0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dds_voice_osc.md
Name: dds_voice_osc

Overview:
Downstream neighbour of note_pitch2dds. It consumes the 32-bit phase increment (ADDER) and runs a phase accumulator once per audio sample tick. It shapes the phase into a signed 16-bit waveform (saw, square, triangle or pulse) and gates the voice on and off with click-free stopping at phase wrap. Its output feeds the voice mixer.

Parameters:
PHASE_W, 32, phase accumulator width; must equal the ADDER width.
OUT_W, 16, signed sample width; the shaper uses phase[PHASE_W-1 -: OUT_W].

Ports:
clk  input  1  system clock, same clock that drives note_pitch2dds.
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
sample_tick  input  1  one-cycle strobe at the audio sample rate.
gate  input  1  note-on level; high means the voice should sound.
sync  input  1  hard-sync request, sampled only on sample_tick.
wave_sel  input  2  waveform select: 0 saw, 1 square, 2 triangle, 3 pulse.
pw  input  8  pulse width for wave_sel=3.
adder  input  32  phase increment from note_pitch2dds, sampled only on sample_tick.
sample  output  16  signed two's-complement waveform sample.
sample_valid  output  1  one-cycle strobe; sample is new in this cycle.
wrap  output  1  one-cycle strobe on phase accumulator carry-out.
active  output  1  high in RUN or DRAIN states.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge) forces:
  - state=IDLE, phase=0;
  - sample=0, sample_valid=0, wrap=0, active=0.
  - Reset mid-operation takes effect at that edge.
  - Any pipelined sample in flight is discarded; no sample_valid follows it.
- State machine, evaluated only on cycles where sample_tick=1:
  - IDLE: phase held at 0.
    - gate=1 → RUN; phase is loaded with 0 on this tick (first sample = phase 0).
  - RUN: phase <= phase + adder (mod 2^32).
    - gate=0 → DRAIN. The accumulate still happens on this tick.
  - DRAIN: phase keeps accumulating.
    - If this tick produces a carry-out → IDLE, and phase is forced to 0 instead of the wrapped value.
    - gate=1 in DRAIN → RUN (legato); phase is not reset.
  - Gate changes between ticks are ignored until the next tick.
- sync=1 on a tick in RUN or DRAIN: phase <= 0.
  - wrap is not asserted for this tick.
  - sync has priority over the DRAIN carry check, so a DRAIN voice that is synced returns to IDLE.
  - sync in IDLE has no effect.
- wrap: high in cycle n+1 when the tick in cycle n produced a carry, excluding sync ticks.
  - wrap is also produced on the final DRAIN carry.
- Pipeline latency:
  - tick high in cycle n → phase register updated, visible in cycle n+1;
  - shaper output registered → sample and sample_valid in cycle n+2.
  - The pipeline is fully pipelined; back-to-back ticks (every cycle) are legal and each produces exactly one sample_valid.
- sample holds its value between sample_valid strobes.
- Shaper, with p = phase[31:16]:
  - saw: p ^ 0x8000.
  - square: phase[31]=0 → 0x7FFF, else 0x8000.
  - triangle: t = p[15] ? ~p[14:0] : p[14:0]; sample = {t,1'b0} ^ 0x8000.
  - pulse: phase[31:24] < pw → 0x7FFF, else 0x8000. pw=0 gives constant 0x8000.
- Ticks processed in IDLE (state stays IDLE) still produce sample_valid, with sample=0.
- active is registered and reflects the state after the tick that changed it, i.e. in cycle n+1.
- wave_sel and pw are sampled alongside the phase in the shaper stage (cycle n+1).

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with tick/gate toggling → sample=0, sample_valid=0, wrap=0, active=0. Assert rst_n=0 mid-RUN → all outputs 0 next cycle and no stale sample_valid.
- Saw start-up: adder=0x01000000, wave_sel=0, gate=1, tick every 4 cycles:
  - first sample 0x8000, second 0x8100;
  - wrap strobe every 256 ticks;
  - sample_valid exactly 2 cycles after each tick.
- Triangle: adder=0x00400000 → at p=0x0000 sample 0x8000; at p=0x4000 sample 0x0000; at p=0x8000 sample 0x7FFE.
- Gate release: adder=0x01000000, gate dropped after tick 100 → active stays 1 through tick 255. Phase 0 after the carry, state IDLE, then samples 0 with sample_valid still pulsing.
- Legato and sync:
  - Gate re-raised during DRAIN → no phase discontinuity, returns to RUN.
  - sync pulse at p=0x8000 → next sample 0x8000 (saw) with no wrap strobe.
- Pulse width: pw=0x40, adder=0x01000000, wave_sel=3 → 64 samples of 0x7FFF then 192 of 0x8000 per cycle. pw=0 → always 0x8000.
